// File: rtl/dmem_byte_ctrl.sv
// Word-wide CPU port onto a byte-wide SRAM: four sequential byte beats per word, little-endian.
// Optional build macro DMEM_RANGE_CHECK_EN rejects requests whose address has any bit set in [31:16].
module dmem_byte_ctrl (
    input  logic        mem_clk,
    input  logic        nreset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [15:0] sram_addr,
    output logic        sram_re,
    output logic        sram_we,
    output logic [7:0]  sram_wdata,
    input  logic [7:0]  sram_rdata
);

    typedef enum logic [2:0] {IDLE, WBEAT, RBEAT, RDRAIN, RESP} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [23:0] rbuf_q, rbuf_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_error_q, rsp_error_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [15:0] sram_addr_q, sram_addr_d;
    logic        sram_re_q, sram_re_d;
    logic        sram_we_q, sram_we_d;
    logic [7:0]  sram_wdata_q, sram_wdata_d;

    logic        accept;
    logic        range_err;
    logic        req_err;

`ifdef DMEM_RANGE_CHECK_EN
    assign range_err = (req_addr[31:16] != 16'h0000);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:16];
    assign range_err      = 1'b0;
`endif

    assign accept  = req_read | req_write;
    assign req_err = (req_read & req_write) | range_err;

    // cnt_q holds the index of the next beat to issue; wrapping to 0 means all four are out.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        rsp_valid_d  = 1'b0;
        rsp_error_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        sram_addr_d  = sram_addr_q;
        sram_re_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_wdata_d = sram_wdata_q;

        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    addr_d  = req_addr[15:0];
                    wdata_d = req_wdata;
                    if (req_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else if (req_write) begin
                        state_d      = WBEAT;
                        cnt_d        = 2'd1;
                        sram_we_d    = 1'b1;
                        sram_addr_d  = req_addr[15:0];
                        sram_wdata_d = req_wdata[7:0];
                    end else begin
                        state_d     = RBEAT;
                        cnt_d       = 2'd1;
                        sram_re_d   = 1'b1;
                        sram_addr_d = req_addr[15:0];
                    end
                end
            end
            WBEAT: begin
                if (cnt_q == 2'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    sram_we_d    = 1'b1;
                    sram_addr_d  = addr_q + {14'h0, cnt_q};
                    sram_wdata_d = wdata_q[{cnt_q, 3'b000} +: 8];
                    cnt_d        = cnt_q + 2'd1;
                end
            end
            RBEAT: begin
                // SRAM data lags its strobe by one cycle, so this cycle returns beat cnt_q-2.
                case (cnt_q)
                    2'd2:    rbuf_d[7:0]   = sram_rdata;
                    2'd3:    rbuf_d[15:8]  = sram_rdata;
                    2'd0:    rbuf_d[23:16] = sram_rdata;
                    default: ;
                endcase
                if (cnt_q == 2'd0) begin
                    state_d = RDRAIN;
                end else begin
                    sram_re_d   = 1'b1;
                    sram_addr_d = addr_q + {14'h0, cnt_q};
                    cnt_d       = cnt_q + 2'd1;
                end
            end
            RDRAIN: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = {sram_rdata, rbuf_q};
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE) || (state_d == RESP);
    end

    always_ff @(posedge mem_clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            addr_q       <= 16'h0;
            wdata_q      <= 32'h0;
            rbuf_q       <= 24'h0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_error_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            sram_addr_q  <= 16'h0;
            sram_re_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_wdata_q <= 8'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_error_q  <= rsp_error_d;
            rsp_rdata_q  <= rsp_rdata_d;
            sram_addr_q  <= sram_addr_d;
            sram_re_q    <= sram_re_d;
            sram_we_q    <= sram_we_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_error  = rsp_error_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign sram_addr  = sram_addr_q;
    assign sram_re    = sram_re_q;
    assign sram_we    = sram_we_q;
    assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_dmem_byte_ctrl.sv
// Scoreboard bench for dmem_byte_ctrl with a behavioural byte-wide SRAM model.
module tb_dmem_byte_ctrl;

    logic        mem_clk = 1'b0;
    logic        nreset;
    logic        req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic [15:0] sram_addr;
    logic        sram_re, sram_we;
    logic [7:0]  sram_wdata, sram_rdata;

    dmem_byte_ctrl dut (
        .mem_clk    (mem_clk),
        .nreset     (nreset),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .sram_addr  (sram_addr),
        .sram_re    (sram_re),
        .sram_we    (sram_we),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          passed = 0;
    int          total  = 0;
    int          cyc    = 0;
    int          strobes = 0;
    int          viol   = 0;
    logic [31:0] model_rd = 32'h0;
    logic [7:0]  mem [0:65535];
    logic        mem_init = 1'b0;

    always @(posedge mem_clk) cyc <= cyc + 1;

    // SRAM model: read data appears the cycle after the strobe.
    always @(posedge mem_clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
            mem[16'h0022] <= 8'h5A;
            mem[16'h0023] <= 8'hA5;
            mem_init      <= 1'b1;
        end else begin
            if (sram_re) sram_rdata <= mem[sram_addr];
            if (sram_we) mem[sram_addr] <= sram_wdata;
        end
        if (nreset && (sram_re || sram_we)) strobes <= strobes + 1;
        if (nreset && sram_re && sram_we)   viol    <= viol + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: actual %h required %h", name, act, exp);
        else passed++;
    endtask

    always @(negedge mem_clk) begin
        if (nreset && rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_cycle", cyc, mon_e.cyc);
                chk("rsp_error", {31'h0, rsp_error}, {31'h0, mon_e.err});
                chk("rsp_rdata", rsp_rdata, mon_e.rdata);
            end
        end
    end

    task automatic rst_chk(input string tag);
        chk({tag, "_ready"},  {31'h0, req_ready},  32'd1);
        chk({tag, "_valid"},  {31'h0, rsp_valid},  32'd0);
        chk({tag, "_error"},  {31'h0, rsp_error},  32'd0);
        chk({tag, "_rdata"},  rsp_rdata,           32'd0);
        chk({tag, "_saddr"},  {16'h0, sram_addr},  32'd0);
        chk({tag, "_re"},     {31'h0, sram_re},    32'd0);
        chk({tag, "_we"},     {31'h0, sram_we},    32'd0);
        chk({tag, "_swdata"}, {24'h0, sram_wdata}, 32'd0);
    endtask

    // lat = response cycle counted from the acceptance edge (cycle 1 = first cycle after it).
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input int lat, input logic exp_err, input logic [31:0] exp_rd,
                         input bit push, output int acc);
        int   n;
        exp_t e;
        n = 0;
        @(negedge mem_clk);
        while (!req_ready && n < 50) begin
            @(negedge mem_clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
        req_read  = rd;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        @(posedge mem_clk);
        #1;
        acc = cyc;
        if (push) begin
            e.cyc   = acc + lat - 1;
            e.err   = exp_err;
            e.rdata = (exp_err || (rd && !wr)) ? exp_rd : model_rd;
            model_rd = e.rdata;
            sb.push_back(e);
        end
        req_read  = 1'b0;
        req_write = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge mem_clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, s0;
        nreset    = 1'b1;
        req_read  = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        #2 nreset = 1'b0;
        #1 rst_chk("rst");
        repeat (3) @(negedge mem_clk);
        nreset = 1'b1;

        // Write then back-to-back read of the same word.
        issue(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5, 1'b0, 32'h0, 1'b1, a1);
        issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 6, 1'b0, 32'hDEAD_BEEF, 1'b1, a2);
        chk("wr_rd_b2b", a2 - a1, 32'd5);
        drain();
        chk("mem10", {24'h0, mem[16'h0010]}, 32'hEF);
        chk("mem11", {24'h0, mem[16'h0011]}, 32'hBE);
        chk("mem12", {24'h0, mem[16'h0012]}, 32'hAD);
        chk("mem13", {24'h0, mem[16'h0013]}, 32'hDE);

        // Address wrap; response must keep the previous read data.
        issue(1'b0, 1'b1, 32'h0000_FFFE, 32'h1122_3344, 5, 1'b0, 32'h0, 1'b1, a1);
        drain();
        chk("memFFFE", {24'h0, mem[16'hFFFE]}, 32'h44);
        chk("memFFFF", {24'h0, mem[16'hFFFF]}, 32'h33);
        chk("mem0000", {24'h0, mem[16'h0000]}, 32'h22);
        chk("mem0001", {24'h0, mem[16'h0001]}, 32'h11);

        // Read and write together.
        s0 = strobes;
        issue(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 1, 1'b1, 32'h0, 1'b1, a1);
        drain();
        chk("both_no_sram", strobes, s0);

        // Upper address bits.
        s0 = strobes;
`ifdef DMEM_RANGE_CHECK_EN
        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0, 1, 1'b1, 32'h0, 1'b1, a1);
        drain();
        chk("range_no_sram", strobes, s0);
`else
        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0, 6, 1'b0, 32'h0000_1122, 1'b1, a1);
        drain();
        chk("range_ignored_strobes", strobes - s0, 32'd4);
`endif

        // Two reads back-to-back out of RESP.
        issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 6, 1'b0, 32'hDEAD_BEEF, 1'b1, a1);
        issue(1'b1, 1'b0, 32'h0000_FFFE, 32'h0, 6, 1'b0, 32'h1122_3344, 1'b1, a2);
        chk("rd_rd_b2b", a2 - a1, 32'd6);
        drain();

        // Reset after two write beats have landed.
        issue(1'b0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 5, 1'b0, 32'h0, 1'b0, a1);
        @(posedge mem_clk);
        @(posedge mem_clk);
        #1 nreset = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        #1 rst_chk("midrst");
        model_rd = 32'h0;
        repeat (2) @(negedge mem_clk);
        nreset = 1'b1;
        repeat (8) @(negedge mem_clk);
        chk("mem20", {24'h0, mem[16'h0020]}, 32'hDD);
        chk("mem21", {24'h0, mem[16'h0021]}, 32'hCC);
        chk("mem22", {24'h0, mem[16'h0022]}, 32'h5A);
        chk("mem23", {24'h0, mem[16'h0023]}, 32'hA5);
        chk("post_rst_ready", {31'h0, req_ready}, 32'd1);

        chk("re_we_overlap", viol, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
